// File: rtl/conv_unit_mc_pkg.sv
// Shared definitions for the multi-channel convolution unit: binary32 constants,
// controller state encoding and the window tap-slice helper.
package conv_pkg;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_SIGN_BIT = 32'h8000_0000;
  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
  localparam int          MAX_TAPS      = 49;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAC  = 3'd1,
    S_WAIT = 3'd2,
    S_BIAS = 3'd3,
    S_OUT  = 3'd4
  } conv_state_e;

  // Tap i of a raster-packed window; callers zero-extend narrower windows.
  function automatic logic [31:0] tap_slice(input logic [MAX_TAPS*32-1:0] vec,
                                            input logic [5:0]              idx);
    return vec[32*int'(idx) +: 32];
  endfunction

  function automatic logic fp32_is_neg(input logic [31:0] v);
    return (v & FP32_SIGN_BIT) != 32'h0000_0000;
  endfunction

endpackage

// File: rtl/conv_unit_mc_fp.sv
// Combinational binary32 multiplier and adder: round-to-nearest-even,
// denormals flushed to signed zero, overflow to infinity, NaN propagated.
module float_mul
  import conv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic              sign_s, a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic              guard_s, sticky_s, inc_s;
  logic [47:0]       prod_s;
  logic [22:0]       mant_s;
  logic [23:0]       mant_rnd_s;
  logic signed [9:0] exp_s, exp_rnd_s;

  // Product, normalisation, rounding and special-case selection
  always_comb begin
    a_zero_s   = (a[30:23] == 8'h00);
    b_zero_s   = (b[30:23] == 8'h00);
    a_inf_s    = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf_s    = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan_s    = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan_s    = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    sign_s     = a[31] ^ b[31];
    prod_s     = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    exp_s      = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod_s[47]) begin
      mant_s   = prod_s[46:24];
      guard_s  = prod_s[23];
      sticky_s = |prod_s[22:0];
      exp_s    = exp_s + 10'sd1;
    end else begin
      mant_s   = prod_s[45:23];
      guard_s  = prod_s[22];
      sticky_s = |prod_s[21:0];
    end
    inc_s      = guard_s & (sticky_s | mant_s[0]);
    mant_rnd_s = {1'b0, mant_s} + {23'd0, inc_s};
    exp_rnd_s  = exp_s + (mant_rnd_s[23] ? 10'sd1 : 10'sd0);

    if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
      y = FP32_QNAN;
    end else if (a_inf_s || b_inf_s) begin
      y = {sign_s, 8'hFF, 23'd0};
    end else if (a_zero_s || b_zero_s) begin
      y = {sign_s, 31'd0};
    end else if (exp_rnd_s >= 10'sd255) begin
      y = {sign_s, 8'hFF, 23'd0};
    end else if (exp_rnd_s <= 10'sd0) begin
      y = {sign_s, 31'd0};
    end else begin
      y = {sign_s, exp_rnd_s[7:0], mant_rnd_s[22:0]};
    end
  end

endmodule

module float_add
  import conv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic              a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic              a_big_s, inc_s;
  logic [31:0]       big_s, sml_s;
  logic [7:0]        ediff_s;
  logic [4:0]        shift_s, lz_s;
  logic [53:0]       align_s;
  logic [26:0]       big_m_s, sml_m_s, diff_s, norm_s;
  logic [27:0]       sum_s;
  logic [23:0]       mant_rnd_s;
  logic signed [9:0] exp_s, exp_rnd_s;

  // Alignment with sticky, add/subtract, normalisation, rounding, specials
  always_comb begin
    a_zero_s = (a[30:23] == 8'h00);
    b_zero_s = (b[30:23] == 8'h00);
    a_inf_s  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf_s  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan_s  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan_s  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_big_s  = (a[30:0] >= b[30:0]);
    big_s    = a_big_s ? a : b;
    sml_s    = a_big_s ? b : a;
    ediff_s  = big_s[30:23] - sml_s[30:23];
    shift_s  = (ediff_s > 8'd27) ? 5'd27 : ediff_s[4:0];
    big_m_s  = {1'b1, big_s[22:0], 3'b000};
    align_s  = {1'b1, sml_s[22:0], 3'b000, 27'd0} >> shift_s;
    sml_m_s  = align_s[53:27] | {26'd0, |align_s[26:0]};
    sum_s    = {1'b0, big_m_s} + {1'b0, sml_m_s};
    diff_s   = big_m_s - sml_m_s;
    lz_s     = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (diff_s[i]) lz_s = 5'(26 - i);
      else           lz_s = lz_s;
    end
    exp_s = $signed({2'b00, big_s[30:23]});
    if (big_s[31] == sml_s[31]) begin
      if (sum_s[27]) begin
        norm_s = sum_s[27:1] | {26'd0, sum_s[0]};
        exp_s  = exp_s + 10'sd1;
      end else begin
        norm_s = sum_s[26:0];
      end
    end else begin
      norm_s = diff_s << lz_s;
      exp_s  = exp_s - $signed({5'd0, lz_s});
    end
    inc_s      = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    mant_rnd_s = {1'b0, norm_s[25:3]} + {23'd0, inc_s};
    exp_rnd_s  = exp_s + (mant_rnd_s[23] ? 10'sd1 : 10'sd0);

    // A missing hidden bit after normalisation means exact cancellation
    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a[31] != b[31]))) begin
      y = FP32_QNAN;
    end else if (a_inf_s) begin
      y = a;
    end else if (b_inf_s) begin
      y = b;
    end else if (a_zero_s && b_zero_s) begin
      y = {a[31] & b[31], 31'd0};
    end else if (a_zero_s) begin
      y = b;
    end else if (b_zero_s) begin
      y = a;
    end else if (!norm_s[26]) begin
      y = FP32_POS_ZERO;
    end else if (exp_rnd_s >= 10'sd255) begin
      y = {big_s[31], 8'hFF, 23'd0};
    end else if (exp_rnd_s <= 10'sd0) begin
      y = {big_s[31], 31'd0};
    end else begin
      y = {big_s[31], exp_rnd_s[7:0], mant_rnd_s[22:0]};
    end
  end

endmodule

// File: rtl/conv_unit_mc.sv
// Multi-channel convolution unit: accumulates IN_CHANNELS KxK windows one tap per
// cycle through a shared binary32 multiplier/adder, then adds bias and optional ReLU.
module conv_unit_mc
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int IN_CHANNELS = 4,
  parameter bit RELU_EN     = 1'b1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] filter,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] image,
  input  logic [DATA_WIDTH-1:0]                      bias,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [DATA_WIDTH-1:0]                      result,
  output logic                                       busy
);
  localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CH_W  = $clog2(IN_CHANNELS) + 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(IN_CHANNELS - 1);

  conv_state_e                  state_r, next_state_s;
  logic [TAPS*DATA_WIDTH-1:0]   filter_r, image_r;
  logic [DATA_WIDTH-1:0]        bias_r, acc_r, result_r;
  logic [TAP_W-1:0]             tap_r;
  logic [CH_W-1:0]              ch_r;
  logic [MAX_TAPS*32-1:0]       filter_ext_s, image_ext_s;
  logic [31:0]                  mul_a_s, mul_b_s, prod_s, add_b_s, sum_s, relu_s;

  // Zero-extend the captured windows to the helper's fixed width and pick the operands
  always_comb begin
    filter_ext_s                  = '0;
    image_ext_s                   = '0;
    filter_ext_s[TAPS*32-1:0]     = filter_r;
    image_ext_s[TAPS*32-1:0]      = image_r;
    mul_a_s = tap_slice(filter_ext_s, 6'(tap_r));
    mul_b_s = tap_slice(image_ext_s, 6'(tap_r));
    add_b_s = (state_r == S_BIAS) ? bias_r : prod_s;
    relu_s  = (RELU_EN && fp32_is_neg(sum_s)) ? FP32_POS_ZERO : sum_s;
  end

  float_mul u_mul (.a(mul_a_s), .b(mul_b_s), .y(prod_s));
  float_add u_add (.a(acc_r),   .b(add_b_s), .y(sum_s));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:  next_state_s = in_valid ? S_MAC : S_IDLE;
      S_MAC: begin
        if (tap_r == LAST_TAP) next_state_s = (ch_r == LAST_CH) ? S_BIAS : S_WAIT;
        else                   next_state_s = S_MAC;
      end
      S_WAIT:  next_state_s = in_valid ? S_MAC : S_WAIT;
      S_BIAS:  next_state_s = S_OUT;
      S_OUT:   next_state_s = out_ready ? S_IDLE : S_OUT;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_r != S_IDLE);
    case (state_r)
      S_IDLE:  in_ready  = 1'b1;
      S_WAIT:  in_ready  = 1'b1;
      S_OUT:   out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Window capture, tap-serial accumulation and result update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filter_r <= '0;
      image_r  <= '0;
      bias_r   <= '0;
      acc_r    <= FP32_POS_ZERO;
      result_r <= FP32_POS_ZERO;
      tap_r    <= '0;
      ch_r     <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            filter_r <= filter;
            image_r  <= image;
            bias_r   <= bias;
            acc_r    <= FP32_POS_ZERO;
            tap_r    <= '0;
            ch_r     <= '0;
          end
        end
        S_WAIT: begin
          if (in_valid) begin
            filter_r <= filter;
            image_r  <= image;
            tap_r    <= '0;
          end
        end
        S_MAC: begin
          acc_r <= sum_s;
          if (tap_r == LAST_TAP) begin
            tap_r <= '0;
            if (ch_r != LAST_CH) ch_r <= ch_r + CH_W'(1);
          end else begin
            tap_r <= tap_r + TAP_W'(1);
          end
        end
        S_BIAS:  result_r <= relu_s;
        default: result_r <= result_r;
      endcase
    end
  end

  assign result = result_r;

endmodule
